// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one physical-memory port between the I-cache (read-only)
// and the D-cache (read/write). One requester at a time. Ties alternate, with D
// winning the first tie after reset. Address and write data are latched at grant
// time and held for the whole transaction.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output logic                  busy
);

  // state      | meaning
  // IDLE       | no transaction; requests are sampled and a grant is made
  // SERVE_I    | line read for the I-side in flight
  // SERVE_D_RD | line read for the D-side in flight
  // SERVE_D_WR | line write-back for the D-side in flight
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D_RD, SERVE_D_WR} state_t;

  // Byte offset within a line; addresses are forced to line alignment.
  localparam int OFS = $clog2(LINE_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << OFS;

  state_t                state;
  logic                  last_grant_d;  // 0: I was granted last, 1: D was granted last
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  d_req;
  logic                  grant_d;

  // Arbitration: D wins if it is the only requester, or on a tie when I went last.
  always_comb begin
    d_req   = d_read | d_write;
    grant_d = d_req & (~i_read | ~last_grant_d);
  end

  // Transaction state, round-robin pointer, and address/data latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_grant_d <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            // A write wins over a read if both are ever raised together.
            state        <= d_write ? SERVE_D_WR : SERVE_D_RD;
            last_grant_d <= 1'b1;
            addr_q       <= d_addr & ADDR_MASK;
            if (d_write) begin
              wdata_q <= d_wdata;
            end
          end else if (i_read) begin
            state        <= SERVE_I;
            last_grant_d <= 1'b0;
            addr_q       <= i_addr & ADDR_MASK;
          end
        end
        default: begin
          if (pmem_resp) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Command and status are decoded from the state register. Responses are
  // steered to the owning side only. Read data is a plain passthrough.
  always_comb begin
    pmem_read    = (state == SERVE_I) || (state == SERVE_D_RD);
    pmem_write   = (state == SERVE_D_WR);
    busy         = (state != IDLE);
    i_resp       = (state == SERVE_I) && pmem_resp;
    d_resp       = ((state == SERVE_D_RD) || (state == SERVE_D_WR)) && pmem_resp;
    pmem_address = addr_q;
    pmem_wdata   = wdata_q;
    i_rdata      = pmem_rdata;
    d_rdata      = pmem_rdata;
  end

endmodule
